regfile_write_sched: RTL and testbench
======================================

// Module: regfile_write_sched
// PURPOSE
// Owns the single write port of the 32x32 register file. It sequences a power-up/on-demand
// clear that writes INIT_VAL to every register, one register per cycle. In normal operation
// it shares the port between CPU writeback and a debug write requester. It sits between the
// writeback stage / debug unit and the register file's reg_write/write_reg_addr/write_data.
// PARAMETERS
// NUM_REGS      32     number of registers cleared (addresses 0..NUM_REGS-1)
// INIT_VAL      32'h0  value written to every register during clear
// STARVE_LIMIT  4      consecutive denied debug cycles before debug preempts CPU (>=1)
// PORTS
// clk            in   1   clock, all state updates on posedge
// rst            in   1   synchronous active-high reset
// clear_req      in   1   pulse: start a full clear (accepted only in RUN)
// cpu_we         in   1   CPU writeback enable
// cpu_addr       in   5   CPU writeback register
// cpu_data       in   32  CPU writeback data
// dbg_req        in   1   debug write request, level; held with addr/data until dbg_ack
// dbg_addr       in   5   debug write register
// dbg_data       in   32  debug write data
// dbg_ack        out  1   registered 1-cycle pulse: debug write performed last cycle
// cpu_stall      out  1   CPU must hold its writeback (port busy this cycle)
// clear_done     out  1   registered 1-cycle pulse after last clear write
// rf_reg_write   out  1   to register file reg_write
// rf_write_addr  out  5   to register file write_reg_addr
// rf_write_data  out  32  to register file write_data
// BEHAVIOUR
// - Reset: state<=CLEAR, clear_idx<=0, starve_cnt<=0, dbg_ack<=0, clear_done<=0.
// - States: CLEAR, RUN. rf_* and cpu_stall are combinational from state and inputs;
//   the register file samples them at the same posedge (zero-latency CPU writes).
// - CLEAR: rf_reg_write=1, rf_write_addr=clear_idx, rf_write_data=INIT_VAL, cpu_stall=1.
//   clear_idx increments each cycle. On the cycle with clear_idx==NUM_REGS-1: next state is
//   RUN, clear_idx<=0, and clear_done=1 on the following cycle. The clear therefore occupies
//   exactly NUM_REGS cycles.
// - CLEAR: dbg_req is not granted and starve_cnt holds at 0. clear_req is ignored.
// - RUN, clear_req=1: this cycle behaves as a normal RUN cycle; next state is CLEAR with
//   clear_idx=0. A pending debug request stays pending.
// - RUN arbitration, evaluated each cycle:
//   * dbg_req=1 and (cpu_we=0 or starve_cnt==STARVE_LIMIT): grant debug.
//     rf_*=dbg_addr/dbg_data with reg_write=1; cpu_stall=cpu_we; starve_cnt<=0; dbg_ack=1 next cycle.
//   * else cpu_we=1: grant CPU. rf_*=cpu_addr/cpu_data; cpu_stall=0.
//     starve_cnt increments when dbg_req=1 (saturates at STARVE_LIMIT), else clears to 0.
//   * else: rf_reg_write=0, starve_cnt<=0.
// - Address 0: any granted write to addr 0 drives rf_reg_write=0 (r0 is hardwired), but it
//   still counts as granted (ack/stall rules unchanged). CLEAR writes all addresses, including 0.
// - dbg_req must deassert the cycle dbg_ack is seen. If it stays high, that counts as a new request.
// - When rf_reg_write=0, rf_write_addr and rf_write_data are don't-care (drive 0).
// - rst mid-clear or mid-arbitration: abandon immediately and restart the clear from index 0.
//   No dbg_ack is issued for an interrupted request.
// TESTING
// 1 rst 1 cycle then low -> rf writes addr 0..31 with INIT_VAL on 32 consecutive cycles,
//   cpu_stall=1 throughout, clear_done=1 on cycle 33, then cpu_stall=0.
// 2 RUN, cpu_we=1 addr=5 data=32'hDEADBEEF -> same cycle rf_reg_write=1, addr 5, data DEADBEEF,
//   cpu_stall=0.
// 3 RUN, cpu_we=0, dbg_req addr=7 data=32'h12345678 -> rf writes 7/12345678 same cycle,
//   dbg_ack=1 next cycle.
// 4 cpu_we=1 continuously with dbg_req held -> CPU wins 4 cycles; 5th cycle debug written with
//   cpu_stall=1; dbg_ack next cycle; CPU resumes.
// 5 cpu_we=1 addr=0 -> rf_reg_write=0, cpu_stall=0; clear_req in RUN -> next 32 cycles CLEAR,
//   clear_done pulse.
// 6 rst asserted at clear_idx=10 -> next cycle clear restarts at addr 0; no clear_done until
//   32 writes complete.

Source files
------------

// File: rtl/regfile_write_sched_if.sv
// Register-file write-port bundle: CPU writeback, debug write requester,
// clear control, and the resulting rf_* write port.
interface regfile_write_sched_if;
  logic        clear_req;
  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  logic        cpu_stall;
  logic        clear_done;
  logic        rf_reg_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  modport slave (
    input  clear_req, cpu_we, cpu_addr, cpu_data,
    input  dbg_req, dbg_addr, dbg_data,
    output dbg_ack, cpu_stall, clear_done,
    output rf_reg_write, rf_write_addr, rf_write_data
  );

  modport master (
    output clear_req, cpu_we, cpu_addr, cpu_data,
    output dbg_req, dbg_addr, dbg_data,
    input  dbg_ack, cpu_stall, clear_done,
    input  rf_reg_write, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: sequential clear, CPU/debug arbitration.
// Ports: clk, rst (sync, active-high), bus (slave view of regfile_write_sched_if).
module regfile_write_sched #(
  parameter int          NUM_REGS     = 32,
  parameter logic [31:0] INIT_VAL     = 32'h0,
  parameter int          STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_sched_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0]    LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    clear_idx_q, clear_idx_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic          clear_done_q, clear_done_d;

  logic          we;
  logic [4:0]    addr;
  logic [31:0]   data;
  logic          stall;
  logic          dbg_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clear_idx_q  <= '0;
      starve_q     <= '0;
      dbg_ack_q    <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_idx_q  <= clear_idx_d;
      starve_q     <= starve_d;
      dbg_ack_q    <= dbg_ack_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_idx_d  = clear_idx_q;
    starve_d     = starve_q;
    dbg_ack_d    = 1'b0;
    clear_done_d = 1'b0;
    we           = 1'b0;
    addr         = '0;
    data         = '0;
    stall        = 1'b0;
    dbg_grant    = 1'b0;

    unique case (state_q)
      CLEAR: begin
        we       = 1'b1;
        addr     = clear_idx_q;
        data     = INIT_VAL;
        stall    = 1'b1;
        starve_d = '0;
        if (clear_idx_q == LAST_IDX) begin
          state_d      = RUN;
          clear_idx_d  = '0;
          clear_done_d = 1'b1;
        end else begin
          clear_idx_d = clear_idx_q + 5'd1;
        end
      end
      RUN: begin
        dbg_grant = bus.dbg_req &&
                    (!bus.cpu_we || starve_q == LIMIT);
        if (dbg_grant) begin
          // r0 is hardwired: the grant still happens, the write does not.
          we        = bus.dbg_addr != 5'd0;
          addr      = we ? bus.dbg_addr : 5'd0;
          data      = we ? bus.dbg_data : 32'd0;
          stall     = bus.cpu_we;
          starve_d  = '0;
          dbg_ack_d = 1'b1;
        end else if (bus.cpu_we) begin
          we   = bus.cpu_addr != 5'd0;
          addr = we ? bus.cpu_addr : 5'd0;
          data = we ? bus.cpu_data : 32'd0;
          if (!bus.dbg_req)
            starve_d = '0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + SW'(1);
        end else begin
          starve_d = '0;
        end
        if (bus.clear_req) begin
          state_d     = CLEAR;
          clear_idx_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign bus.rf_reg_write  = we;
  assign bus.rf_write_addr = addr;
  assign bus.rf_write_data = data;
  assign bus.cpu_stall     = stall;
  assign bus.dbg_ack       = dbg_ack_q;
  assign bus.clear_done    = clear_done_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Testbench for regfile_write_sched: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the write port.
module tb_regfile_write_sched;

  localparam int          NREG  = 32;
  localparam logic [31:0] IVAL  = 32'h0;
  localparam int          LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_sched_if bus ();

  regfile_write_sched #(
    .NUM_REGS(NREG), .INIT_VAL(IVAL), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: "clearing" plus how many clear writes are done; "denied" counts
  // consecutive cycles a pending debug request lost to the CPU.
  bit m_clearing;
  int m_cleared;
  int m_denied;
  bit m_ack;
  bit m_done;

  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          e_stall;
  bit          e_grant;

  function automatic void model_comb();
    e_we = 0; e_addr = '0; e_data = '0; e_stall = 0; e_grant = 0;
    if (m_clearing) begin
      e_we = 1; e_addr = 5'(m_cleared); e_data = IVAL; e_stall = 1;
    end else begin
      e_grant = bus.dbg_req && (!bus.cpu_we || m_denied >= LIMIT);
      if (e_grant) begin
        e_stall = bus.cpu_we;
        if (bus.dbg_addr != 0) begin
          e_we = 1; e_addr = bus.dbg_addr; e_data = bus.dbg_data;
        end
      end else if (bus.cpu_we && bus.cpu_addr != 0) begin
        e_we = 1; e_addr = bus.cpu_addr; e_data = bus.cpu_data;
      end
    end
  endfunction

  function automatic void model_tick();
    model_comb();
    if (rst) begin
      m_clearing = 1; m_cleared = 0; m_denied = 0;
      m_ack = 0; m_done = 0;
    end else if (m_clearing) begin
      m_ack = 0; m_denied = 0;
      m_cleared++;
      m_done = (m_cleared == NREG);
      if (m_done) begin
        m_clearing = 0; m_cleared = 0;
      end
    end else begin
      m_done = 0;
      m_ack  = e_grant;
      if (e_grant)                       m_denied = 0;
      else if (bus.cpu_we && bus.dbg_req) m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
      else                               m_denied = 0;
      if (bus.clear_req) begin
        m_clearing = 1; m_cleared = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.dbg_req = 0; bus.dbg_addr = '0; bus.dbg_data = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (bus.dbg_ack !== 1'b0 || bus.clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs ack=%b done=%b want 0/0", bus.dbg_ack, bus.clear_done);
    end
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'(i) ||
          bus.rf_write_data !== IVAL || bus.cpu_stall !== 1'b1 ||
          bus.clear_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_clear[%0d] we=%b addr=%0d data=%h stall=%b done=%b want 1/%0d/%h/1/0",
                 i, bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data,
                 bus.cpu_stall, bus.clear_done, i, IVAL);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (bus.clear_done !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.rf_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done done=%b stall=%b we=%b want 1/0/0",
               bus.clear_done, bus.cpu_stall, bus.rf_reg_write);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done_pulse done=%b want 0", bus.clear_done);
    end
  endtask

  task automatic test_cpu_write();
    bus.cpu_we = 1; bus.cpu_addr = 5'd5; bus.cpu_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd5 ||
        bus.rf_write_data !== 32'hDEADBEEF || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_write we=%b addr=%0d data=%h stall=%b want 1/5/deadbeef/0",
               bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data, bus.cpu_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_dbg_write();
    bus.dbg_req = 1; bus.dbg_addr = 5'd7; bus.dbg_data = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd7 ||
        bus.rf_write_data !== 32'h12345678 || bus.dbg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL dbg_write we=%b addr=%0d data=%h ack=%b want 1/7/12345678/0",
               bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data, bus.dbg_ack);
    end
    tick();
    n_checks++;
    if (bus.dbg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL dbg_ack ack=%b want 1", bus.dbg_ack);
    end
    bus.dbg_req = 0;
    tick();
    n_checks++;
    if (bus.dbg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL dbg_ack_pulse ack=%b want 0", bus.dbg_ack);
    end
  endtask

  task automatic test_starve();
    bus.cpu_we = 1; bus.cpu_addr = 5'd3; bus.cpu_data = 32'hC0C0_0003;
    bus.dbg_req = 1; bus.dbg_addr = 5'd9; bus.dbg_data = 32'hD0D0_0009;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rf_write_addr !== 5'd3 || bus.cpu_stall !== 1'b0 || bus.dbg_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_cpu[%0d] addr=%0d stall=%b ack=%b want 3/0/0",
                 k, bus.rf_write_addr, bus.cpu_stall, bus.dbg_ack);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd9 ||
        bus.rf_write_data !== 32'hD0D0_0009 || bus.cpu_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_dbg we=%b addr=%0d data=%h stall=%b want 1/9/d0d00009/1",
               bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data, bus.cpu_stall);
    end
    tick();
    n_checks++;
    if (bus.dbg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_ack ack=%b want 1", bus.dbg_ack);
    end
    bus.dbg_req = 0;
    @(negedge clk);
    n_checks++;
    if (bus.rf_write_addr !== 5'd3 || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_resume addr=%0d stall=%b want 3/0",
               bus.rf_write_addr, bus.cpu_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_addr0_clear();
    bus.cpu_we = 1; bus.cpu_addr = 5'd0; bus.cpu_data = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if (bus.rf_reg_write !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL addr0 we=%b stall=%b want 0/0", bus.rf_reg_write, bus.cpu_stall);
    end
    tick();
    bus.cpu_addr = 5'd4; bus.cpu_data = 32'h0000_0044; bus.clear_req = 1;
    @(negedge clk);
    n_checks++;
    if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'd4 || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_req_cycle we=%b addr=%0d stall=%b want 1/4/0",
               bus.rf_reg_write, bus.rf_write_addr, bus.cpu_stall);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rf_reg_write !== 1'b1 || bus.rf_write_addr !== 5'(i) ||
          bus.cpu_stall !== 1'b1 || bus.clear_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reclear[%0d] we=%b addr=%0d stall=%b done=%b want 1/%0d/1/0",
                 i, bus.rf_reg_write, bus.rf_write_addr, bus.cpu_stall, bus.clear_done, i);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (bus.clear_done !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reclear_done done=%b stall=%b want 1/0", bus.clear_done, bus.cpu_stall);
    end
    tick();
  endtask

  task automatic test_rst_mid_clear();
    bus.clear_req = 1;
    tick();
    bus.clear_req = 0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    n_checks++;
    if (bus.rf_write_addr !== 5'd10) begin
      n_fail++;
      $display("FAIL mid_clear_idx addr=%0d want 10", bus.rf_write_addr);
    end
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rf_write_addr !== 5'(i) || bus.rf_reg_write !== 1'b1 ||
          bus.clear_done !== 1'b0) begin
        n_fail++;
        $display("FAIL restart[%0d] addr=%0d we=%b done=%b want %0d/1/0",
                 i, bus.rf_write_addr, bus.rf_reg_write, bus.clear_done, i);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (bus.clear_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done done=%b want 1", bus.clear_done);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (bus.dbg_ack) bus.dbg_req = 0;
      else if (!bus.dbg_req && $urandom_range(3) == 0) begin
        bus.dbg_req  = 1;
        bus.dbg_addr = 5'($urandom);
        bus.dbg_data = $urandom;
      end
      bus.cpu_we    = ($urandom_range(3) != 0);
      bus.cpu_addr  = 5'($urandom);
      bus.cpu_data  = $urandom;
      bus.clear_req = ($urandom_range(79) == 0);
      rst           = ($urandom_range(399) == 0);
      @(negedge clk);
      model_comb();
      n_checks++;
      if (bus.rf_reg_write !== e_we || bus.rf_write_addr !== e_addr ||
          bus.rf_write_data !== e_data || bus.cpu_stall !== e_stall ||
          bus.dbg_ack !== m_ack || bus.clear_done !== m_done) begin
        n_fail++;
        $display("FAIL random[%0d] we=%b addr=%0d data=%h stall=%b ack=%b done=%b want %b/%0d/%h/%b/%b/%b",
                 c, bus.rf_reg_write, bus.rf_write_addr, bus.rf_write_data,
                 bus.cpu_stall, bus.dbg_ack, bus.clear_done,
                 e_we, e_addr, e_data, e_stall, m_ack, m_done);
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_clearing = 1; m_cleared = 0; m_denied = 0; m_ack = 0; m_done = 0;
    #2;
    test_reset();
    test_cpu_write();
    test_dbg_write();
    test_starve();
    test_addr0_clear();
    test_rst_mid_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
